instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Encoder counterpart of the control unit: packs opcode class plus register/immediate fields into 32-bit MIPS words.
//  Buffers encoded words in a small FIFO and writes them sequentially into instruction memory from address 0.
//  Sits between the test/boot program source and the instruction memory; the control unit later decodes these words.
// PARAMETERS
//  ADDR_W      8  instruction-memory word-address width; capacity 2**ADDR_W words
//  FIFO_DEPTH  4  encoded-word buffer entries (power of 2, >=2)
// PORTS
//  clk_in         in   1        clock, rising edge
//  reset_in       in   1        synchronous, active-high reset
//  start_in       in   1        begin/restart a load: addr<=0, FIFO flushed, error cleared
//  valid_in       in   1        source has an instruction on the field inputs
//  ready_out      out  1        encoder accepts this cycle (transfer = valid_in & ready_out)
//  op_sel_in      in   4        0 ADD,1 SUB,2 OR,3 SLT,4 AND,5 ADDI,6 LW,7 SW,8 BEQ,9 J; 10-15 illegal
//  rs_in          in   5        source register
//  rt_in          in   5        target register
//  rd_in          in   5        destination register (R-type only)
//  imm_in         in   16       immediate / offset (I-type only)
//  target_in      in   26       jump target (J only)
//  imem_we_out    out  1        instruction-memory write strobe
//  imem_addr_out  out  ADDR_W   write word address
//  imem_data_out  out  32       encoded instruction word
//  count_out      out  ADDR_W+1 words written since start_in
//  full_out       out  1        memory filled; load complete
//  error_out      out  1        sticky: an illegal op_sel_in was accepted
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; FIFO empty; write pointer 0.
//  - States: IDLE -(start_in)-> RUN -(last address written)-> DONE -(start_in)-> RUN. start_in in RUN also restarts.
//  - ready_out = (state==RUN) & !fifo_full, from registered state; no same-cycle bypass when full.
//  - Encoding (combinational, registered on FIFO push):
//    R: {6'b000000,rs,rt,rd,5'b0,funct}; funct ADD 100000, SUB 100010, OR 100101, SLT 101010, AND 100100
//    I: {op,rs,rt,imm}; op ADDI 001000, LW 100011, SW 101011, BEQ 000100
//    J: {6'b000010,target}
//  - Illegal op_sel: transfer completes (handshake honoured), nothing pushed, error_out<=1 until start_in/reset.
//  - Writer: in RUN, if FIFO non-empty, pop one entry per cycle; the registered outputs show
//    imem_we_out=1, imem_addr_out=ptr, imem_data_out=word for exactly one cycle; ptr+1, count_out+1.
//  - Latency: word accepted at edge N with FIFO empty -> imem_we_out high in the cycle after edge N+1.
//  - Simultaneous push and pop are allowed in the same cycle; occupancy is unchanged.
//  - Boundary: the write to address 2**ADDR_W-1 moves to DONE: full_out=1, ready_out=0, FIFO flushed,
//    count_out=2**ADDR_W. No wrap; the pointer stays at 0 until start_in.
//  - start_in has priority over every other event in the same cycle; any in-flight transfer is dropped.
//  - reset_in in mid-load returns to IDLE; no write strobe in the following cycle.
//  - imem_we_out=0 whenever not popping; data/addr hold their last value.
// TESTING
//  T1 start, ADD rs1 rt2 rd3 -> one strobe, addr 0, data 0x00221820, count 1
//  T2 ADDI rs0 rt8 imm5; LW rs29 rt31 imm FFFC; SLT rs4 rt5 rd6; J 0x0100000 back-to-back ->
//     addr 0..3 data 0x20080005, 0x8FBFFFFC, 0x0085302A, 0x08100000, no gaps after first
//  T3 ADDR_W=2, 5 valid words -> 4 writes, full_out=1, ready_out=0 after 4th, 5th word never written
//  T4 op_sel 12 accepted between two ADDs -> error_out=1, only two strobes at addr 0,1
//  T5 start_in asserted with 3 words buffered -> FIFO flushed, next word written at addr 0, error_out=0
//  T6 reset_in mid-stream -> next cycle all outputs 0, ready_out=0 until start_in

Source files
------------

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Purpose:
//   Packs an opcode class plus register/immediate/target fields into 32-bit
//   MIPS instruction words, buffers them in a small FIFO and writes them one
//   per cycle into instruction memory, starting at word address 0. This is the
//   encoder counterpart of the control unit, which later decodes these words.
//
// Parameters:
//   ADDR_W      instruction-memory word-address width (capacity 2**ADDR_W)
//   FIFO_DEPTH  encoded-word buffer entries (power of 2, >= 2)
//
// Ports:
//   clk_in         clock, rising edge
//   reset_in       synchronous active-high reset
//   start_in       begin/restart a load (address 0, FIFO flushed, error cleared)
//   valid_in       source presents an instruction on the field inputs
//   ready_out      encoder accepts this cycle (transfer = valid_in & ready_out)
//   op_sel_in      0 ADD,1 SUB,2 OR,3 SLT,4 AND,5 ADDI,6 LW,7 SW,8 BEQ,9 J
//   rs_in/rt_in    source / target register
//   rd_in          destination register (R-type only)
//   imm_in         immediate / offset (I-type only)
//   target_in      jump target (J only)
//   imem_we_out    instruction-memory write strobe (one cycle per word)
//   imem_addr_out  write word address
//   imem_data_out  encoded instruction word
//   count_out      words written since start_in
//   full_out       memory filled; load complete
//   error_out      sticky: an illegal op_sel_in was accepted
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              start_in,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [3:0]        op_sel_in,
    input  logic [4:0]        rs_in,
    input  logic [4:0]        rt_in,
    input  logic [4:0]        rd_in,
    input  logic [15:0]       imm_in,
    input  logic [25:0]       target_in,
    output logic              imem_we_out,
    output logic [ADDR_W-1:0] imem_addr_out,
    output logic [31:0]       imem_data_out,
    output logic [ADDR_W:0]   count_out,
    output logic              full_out,
    output logic              error_out
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = IDX_W + 1;
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Opcode classes 10..15 are not defined and must never reach memory.
    function automatic logic op_legal(input logic [3:0] op_sel);
        logic legal;
        legal = (op_sel <= 4'd9);
        return legal;
    endfunction

    // Field packing for the three MIPS formats; unused fields are ignored.
    function automatic logic [31:0] encode_word(
        input logic [3:0]  op_sel,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [31:0] word;
        case (op_sel)
            4'd0:    word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
            4'd1:    word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
            4'd2:    word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
            4'd3:    word = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
            4'd4:    word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
            4'd5:    word = {6'b001000, rs, rt, imm};
            4'd6:    word = {6'b100011, rs, rt, imm};
            4'd7:    word = {6'b101011, rs, rt, imm};
            4'd8:    word = {6'b000100, rs, rt, imm};
            4'd9:    word = {6'b000010, target};
            default: word = 32'h0000_0000;
        endcase
        return word;
    endfunction

    state_t            state_q, state_d;
    logic [31:0]       fifo_mem_q [FIFO_DEPTH];
    logic [31:0]       fifo_mem_d [FIFO_DEPTH];
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              full_q, full_d;
    logic              error_q, error_d;

    logic              ready_s;
    logic              legal_s;
    logic [31:0]       enc_word_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic              last_write_s;

    // Handshake and FIFO control strobes; start_in suppresses every other event.
    always_comb begin
        ready_s      = (state_q == ST_RUN) && (occ_q != OCC_FULL);
        legal_s      = op_legal(op_sel_in);
        enc_word_s   = encode_word(op_sel_in, rs_in, rt_in, rd_in, imm_in, target_in);
        accept_s     = valid_in && ready_s && !start_in;
        push_s       = accept_s && legal_s;
        pop_s        = (state_q == ST_RUN) && (occ_q != {OCC_W{1'b0}}) && !start_in;
        last_write_s = pop_s && (ptr_q == LAST_ADDR);
    end

    // Next-state for the load FSM, FIFO, memory writer and status flags.
    always_comb begin
        state_d    = state_q;
        fifo_mem_d = fifo_mem_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        occ_d      = occ_q;
        ptr_d      = ptr_q;
        count_d    = count_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        full_d     = full_q;
        error_d    = error_q;

        if (start_in) begin
            state_d  = ST_RUN;
            wr_idx_d = {IDX_W{1'b0}};
            rd_idx_d = {IDX_W{1'b0}};
            occ_d    = {OCC_W{1'b0}};
            ptr_d    = {ADDR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
            full_d   = 1'b0;
            error_d  = 1'b0;
        end else begin
            if (pop_s) begin
                we_d     = 1'b1;
                addr_d   = ptr_q;
                data_d   = fifo_mem_q[rd_idx_q];
                count_d  = count_q + CNT_W'(1);
                rd_idx_d = rd_idx_q + IDX_W'(1);
            end else begin
                we_d = 1'b0;
            end

            if (last_write_s) begin
                // Memory is full: finish the load and discard anything still buffered,
                // including a word accepted in this same cycle.
                state_d  = ST_DONE;
                full_d   = 1'b1;
                ptr_d    = {ADDR_W{1'b0}};
                wr_idx_d = {IDX_W{1'b0}};
                rd_idx_d = {IDX_W{1'b0}};
                occ_d    = {OCC_W{1'b0}};
            end else begin
                if (pop_s) begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end else begin
                    ptr_d = ptr_q;
                end
                if (push_s) begin
                    fifo_mem_d[wr_idx_q] = enc_word_s;
                    wr_idx_d             = wr_idx_q + IDX_W'(1);
                end else begin
                    wr_idx_d = wr_idx_q;
                end
                case ({push_s, pop_s})
                    2'b10:   occ_d = occ_q + OCC_W'(1);
                    2'b01:   occ_d = occ_q - OCC_W'(1);
                    default: occ_d = occ_q;
                endcase
            end

            // The illegal word is consumed by the handshake but never buffered.
            if (accept_s && !legal_s) begin
                error_d = 1'b1;
            end else begin
                error_d = error_q;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= 32'h0000_0000;
            end
            wr_idx_q <= {IDX_W{1'b0}};
            rd_idx_q <= {IDX_W{1'b0}};
            occ_q    <= {OCC_W{1'b0}};
            ptr_q    <= {ADDR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            we_q     <= 1'b0;
            addr_q   <= {ADDR_W{1'b0}};
            data_q   <= 32'h0000_0000;
            full_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fifo_mem_q <= fifo_mem_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            occ_q      <= occ_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            full_q     <= full_d;
            error_q    <= error_d;
        end
    end

    assign ready_out     = ready_s;
    assign imem_we_out   = we_q;
    assign imem_addr_out = addr_q;
    assign imem_data_out = data_q;
    assign count_out     = count_q;
    assign full_out      = full_q;
    assign error_out     = error_q;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//
// Self-checking bench for instr_encoder. A default instance (ADDR_W=8) is
// compared every cycle against a queue-based reference model; a second instance
// with ADDR_W=2 shares the stimulus and is used for the memory-full boundary.
// Directed vectors come from a table of hand-encoded words.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

    localparam int DEPTH = 4;
    localparam int CAP   = 256;

    localparam int OPC_TAB [10] = '{0, 0, 0, 0, 0, 8, 35, 43, 4, 2};
    localparam int FN_TAB  [10] = '{32, 34, 37, 42, 36, 0, 0, 0, 0, 0};

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    logic        clk_in = 1'b0;
    logic        reset_in, start_in, valid_in;
    logic [3:0]  op_sel_in;
    logic [4:0]  rs_in, rt_in, rd_in;
    logic [15:0] imm_in;
    logic [25:0] target_in;

    logic        ready_out, imem_we_out, full_out, error_out;
    logic [7:0]  imem_addr_out;
    logic [31:0] imem_data_out;
    logic [8:0]  count_out;

    logic        s_ready, s_we, s_full, s_err;
    logic [1:0]  s_addr;
    logic [31:0] s_data;
    logic [2:0]  s_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    vec_t vecs [14];

    logic [7:0]  obs_addr [$];
    logic [31:0] obs_data [$];
    int          obs_cyc  [$];
    logic [1:0]  s_obs_addr [$];
    logic [31:0] s_obs_data [$];

    // reference model state
    int unsigned m_q [$];
    bit          m_run, m_full, m_err, m_we;
    int          m_ptr, m_cnt;
    logic [7:0]  m_addr;
    logic [31:0] m_data;
    bit          m_ready_now, m_xfer, m_legal, m_filled, exp_ready;
    logic [31:0] m_w;

    always #5 clk_in = ~clk_in;

    instr_encoder #(.ADDR_W(8), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk_in(clk_in), .reset_in(reset_in), .start_in(start_in), .valid_in(valid_in),
        .ready_out(ready_out), .op_sel_in(op_sel_in), .rs_in(rs_in), .rt_in(rt_in),
        .rd_in(rd_in), .imm_in(imm_in), .target_in(target_in),
        .imem_we_out(imem_we_out), .imem_addr_out(imem_addr_out),
        .imem_data_out(imem_data_out), .count_out(count_out),
        .full_out(full_out), .error_out(error_out)
    );

    instr_encoder #(.ADDR_W(2), .FIFO_DEPTH(DEPTH)) u_small (
        .clk_in(clk_in), .reset_in(reset_in), .start_in(start_in), .valid_in(valid_in),
        .ready_out(s_ready), .op_sel_in(op_sel_in), .rs_in(rs_in), .rt_in(rt_in),
        .rd_in(rd_in), .imm_in(imm_in), .target_in(target_in),
        .imem_we_out(s_we), .imem_addr_out(s_addr),
        .imem_data_out(s_data), .count_out(s_count),
        .full_out(s_full), .error_out(s_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Word value built from the opcode/funct tables with plain arithmetic.
    function automatic void ref_encode(input logic [3:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [15:0] imm, input logic [25:0] tgt,
                                       output bit legal, output logic [31:0] w);
        longint unsigned acc;
        int idx;
        idx   = int'(op);
        legal = (idx < 10);
        acc   = 0;
        if (!legal) acc = 0;
        else if (idx < 5)
            acc = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048
                + longint'(FN_TAB[idx]);
        else if (idx < 9)
            acc = longint'(OPC_TAB[idx]) * 67108864 + longint'(rs) * 2097152
                + longint'(rt) * 65536 + longint'(imm);
        else
            acc = longint'(OPC_TAB[idx]) * 67108864 + longint'(tgt);
        w = acc[31:0];
    endfunction

    // Reference model: one step per rising edge, queue holds accepted words.
    always @(posedge clk_in) begin
        m_ready_now = m_run && (m_q.size() < DEPTH);
        m_we        = 1'b0;
        m_filled    = 1'b0;
        if (reset_in) begin
            m_run = 0; m_full = 0; m_err = 0; m_q.delete();
            m_ptr = 0; m_cnt = 0; m_addr = 8'd0; m_data = 32'd0;
        end else if (start_in) begin
            m_run = 1; m_full = 0; m_err = 0; m_q.delete();
            m_ptr = 0; m_cnt = 0;
        end else begin
            m_xfer = valid_in && m_ready_now;
            if (m_run && m_q.size() != 0) begin
                m_we   = 1'b1;
                m_addr = 8'(m_ptr);
                m_data = m_q.pop_front();
                m_cnt++;
                if (m_ptr == CAP - 1) begin
                    m_run = 0; m_full = 1; m_ptr = 0; m_q.delete(); m_filled = 1;
                end else begin
                    m_ptr++;
                end
            end
            if (m_xfer) begin
                ref_encode(op_sel_in, rs_in, rt_in, rd_in, imm_in, target_in, m_legal, m_w);
                if (!m_legal) m_err = 1'b1;
                else if (!m_filled) m_q.push_back(m_w);
            end
        end
    end

    // Output sampling, write logging and per-cycle model comparison.
    always @(negedge clk_in) begin
        cyc++;
        if (imem_we_out === 1'b1) begin
            obs_addr.push_back(imem_addr_out);
            obs_data.push_back(imem_data_out);
            obs_cyc.push_back(cyc);
        end
        if (s_we === 1'b1) begin
            s_obs_addr.push_back(s_addr);
            s_obs_data.push_back(s_data);
        end
        if (mon_en) begin
            exp_ready = m_run && (m_q.size() < DEPTH);
            check("cycle_outputs",
                  {ready_out, imem_we_out, full_out, error_out, count_out, imem_addr_out, imem_data_out},
                  {exp_ready, m_we, m_full, m_err, 9'(m_cnt), m_addr, m_data});
        end
    end

    task automatic clear_obs();
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
        s_obs_addr.delete(); s_obs_data.delete();
    endtask

    task automatic drive(input vec_t v);
        op_sel_in = v.op; rs_in = v.rs; rt_in = v.rt; rd_in = v.rd;
        imm_in = v.imm; target_in = v.tgt;
    endtask

    task automatic do_start();
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
    endtask

    task automatic drain();
        repeat (8) @(negedge clk_in);
    endtask

    // Present one instruction and hold it until the handshake completes (bounded).
    task automatic send(input vec_t v);
        int waited;
        waited = 0;
        drive(v);
        valid_in = 1'b1;
        while (ready_out !== 1'b1 && waited < 50) begin
            @(negedge clk_in);
            waited++;
        end
        check("send_ready", 64'(ready_out), 64'd1);
        @(negedge clk_in);
        valid_in = 1'b0;
    endtask

    initial begin
        int k;
        vecs[0]  = '{4'd0,  5'd1,  5'd2,  5'd3,  16'hBEEF, 26'h3ABCDEF, 1'b1, 32'h00221820};
        vecs[1]  = '{4'd5,  5'd0,  5'd8,  5'd17, 16'h0005, 26'h1234567, 1'b1, 32'h20080005};
        vecs[2]  = '{4'd6,  5'd29, 5'd31, 5'd5,  16'hFFFC, 26'h2222222, 1'b1, 32'h8FBFFFFC};
        vecs[3]  = '{4'd3,  5'd4,  5'd5,  5'd6,  16'h1234, 26'h3FFFFFF, 1'b1, 32'h0085302A};
        vecs[4]  = '{4'd9,  5'd9,  5'd10, 5'd11, 16'h5555, 26'h0100000, 1'b1, 32'h08100000};
        vecs[5]  = '{4'd1,  5'd7,  5'd8,  5'd9,  16'hFFFF, 26'h0000001, 1'b1, 32'h00E84822};
        vecs[6]  = '{4'd2,  5'd10, 5'd11, 5'd12, 16'hA5A5, 26'h1555555, 1'b1, 32'h014B6025};
        vecs[7]  = '{4'd4,  5'd31, 5'd31, 5'd31, 16'h00FF, 26'h2AAAAAA, 1'b1, 32'h03FFF824};
        vecs[8]  = '{4'd7,  5'd2,  5'd3,  5'd30, 16'h0010, 26'h3000000, 1'b1, 32'hAC430010};
        vecs[9]  = '{4'd8,  5'd1,  5'd2,  5'd4,  16'hFFFF, 26'h0FFFFFF, 1'b1, 32'h1022FFFF};
        vecs[10] = '{4'd12, 5'd1,  5'd2,  5'd3,  16'h1111, 26'h0000000, 1'b0, 32'h00000000};
        vecs[11] = '{4'd5,  5'd31, 5'd0,  5'd21, 16'h8000, 26'h0ABCDEF, 1'b1, 32'h23E08000};
        vecs[12] = '{4'd9,  5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 1'b1, 32'h0BFFFFFF};
        vecs[13] = '{4'd15, 5'd3,  5'd4,  5'd5,  16'h2222, 26'h0000000, 1'b0, 32'h00000000};

        reset_in = 1'b1; start_in = 1'b0; valid_in = 1'b0;
        drive(vecs[0]);
        repeat (2) @(negedge clk_in);

        // reset state
        check("reset_outputs",
              {ready_out, imem_we_out, full_out, error_out, count_out, imem_addr_out, imem_data_out},
              64'd0);
        reset_in = 1'b0;
        mon_en   = 1'b1;
        @(negedge clk_in);
        check("idle_not_ready", 64'(ready_out), 64'd0);

        // T1: single ADD, latency and single strobe
        do_start();
        drive(vecs[0]);
        valid_in = 1'b1;
        @(negedge clk_in);
        valid_in = 1'b0;
        check("t1_no_strobe_yet", 64'(imem_we_out), 64'd0);
        @(negedge clk_in);
        check("t1_we", 64'(imem_we_out), 64'd1);
        check("t1_addr", 64'(imem_addr_out), 64'd0);
        check("t1_data", 64'(imem_data_out), 64'h00221820);
        check("t1_count", 64'(count_out), 64'd1);
        @(negedge clk_in);
        check("t1_single_strobe", 64'(imem_we_out), 64'd0);
        drain();

        // T2: four back-to-back words, no gaps
        clear_obs();
        do_start();
        for (int i = 1; i <= 4; i++) send(vecs[i]);
        drain();
        check("t2_nwrites", 64'(obs_addr.size()), 64'd4);
        for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
            check("t2_addr", 64'(obs_addr[i]), 64'(i));
            check("t2_data", 64'(obs_data[i]), 64'(vecs[i+1].word));
            if (i > 0) check("t2_no_gap", 64'(obs_cyc[i] - obs_cyc[i-1]), 64'd1);
        end

        // Table: all opcode classes with junk in unused fields
        clear_obs();
        do_start();
        for (int i = 0; i < 14; i++) send(vecs[i]);
        drain();
        check("tab_nwrites", 64'(obs_addr.size()), 64'd12);
        k = 0;
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].legal && k < obs_addr.size()) begin
                check("tab_addr", 64'(obs_addr[k]), 64'(k));
                check("tab_data", 64'(obs_data[k]), 64'(vecs[i].word));
                k++;
            end
        end
        check("tab_error", 64'(error_out), 64'd1);

        // T4: illegal op between two ADDs
        clear_obs();
        do_start();
        check("t4_error_cleared", 64'(error_out), 64'd0);
        send(vecs[0]); send(vecs[10]); send(vecs[0]);
        drain();
        check("t4_error", 64'(error_out), 64'd1);
        check("t4_nwrites", 64'(obs_addr.size()), 64'd2);
        for (int i = 0; i < 2 && i < obs_addr.size(); i++)
            check("t4_addr", 64'(obs_addr[i]), 64'(i));
        check("t4_count", 64'(count_out), 64'd2);

        // T5: restart with words in flight; new load begins at address 0
        do_start();
        send(vecs[13]);
        send(vecs[5]); send(vecs[6]); send(vecs[7]);
        drive(vecs[8]);
        valid_in = 1'b1;
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        valid_in = 1'b0;
        clear_obs();
        check("t5_error_cleared", 64'(error_out), 64'd0);
        check("t5_count_cleared", 64'(count_out), 64'd0);
        send(vecs[9]);
        drain();
        check("t5_nwrites", 64'(obs_addr.size()), 64'd1);
        if (obs_addr.size() > 0) begin
            check("t5_addr", 64'(obs_addr[0]), 64'd0);
            check("t5_data", 64'(obs_data[0]), 64'(vecs[9].word));
        end

        // T3: small memory fills after four writes, fifth word never written
        clear_obs();
        do_start();
        for (int i = 1; i <= 5; i++) send(vecs[i]);
        drain();
        check("t3_nwrites", 64'(s_obs_addr.size()), 64'd4);
        for (int i = 0; i < 4 && i < s_obs_addr.size(); i++) begin
            check("t3_addr", 64'(s_obs_addr[i]), 64'(i));
            check("t3_data", 64'(s_obs_data[i]), 64'(vecs[i+1].word));
        end
        check("t3_full", 64'(s_full), 64'd1);
        check("t3_not_ready", 64'(s_ready), 64'd0);
        check("t3_count", 64'(s_count), 64'd4);

        // T6: reset in mid-stream
        do_start();
        send(vecs[0]); send(vecs[5]);
        reset_in = 1'b1;
        @(negedge clk_in);
        check("t6_outputs_zero",
              {ready_out, imem_we_out, full_out, error_out, count_out, imem_addr_out, imem_data_out},
              64'd0);
        reset_in = 1'b0;
        repeat (3) begin
            @(negedge clk_in);
            check("t6_idle_ready", 64'(ready_out), 64'd0);
            check("t6_idle_we", 64'(imem_we_out), 64'd0);
        end
        do_start();
        check("t6_ready_after_start", 64'(ready_out), 64'd1);

        // Random traffic checked cycle by cycle against the model
        for (int c = 0; c < 1500; c++) begin
            valid_in  = ($urandom_range(0, 3) != 0);
            op_sel_in = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                    : 4'($urandom_range(0, 9));
            rs_in     = 5'($urandom);
            rt_in     = 5'($urandom);
            rd_in     = 5'($urandom);
            imm_in    = 16'($urandom);
            target_in = 26'($urandom);
            start_in  = ($urandom_range(0, 299) == 0) || (c == 700);
            @(negedge clk_in);
        end
        valid_in = 1'b0;
        start_in = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
